w_sched: RTL

- Layer/neuron scheduler for the fixed weight store `w_mem`.
- On `start`, latches the 4-bit weight-set selection and drives it to `w_mem.choice`.
- Walks layers G2 → G3 → D2 → D3 in order and presents one neuron's weight row per handshake to the downstream neuron MAC.
- Sits between `w_mem` (combinational weight buses) and the MAC datapath; it is the only agent that sequences weight fetches.

---
 rtl/w_sched_pkg.sv | 32 +++
 rtl/w_row_sel.sv | 113 +++++++++++
 rtl/w_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/w_sched_pkg.sv
// ============================================================================
// Module  : w_sched_pkg
// Purpose : Shared layer encoding, default layer sizes and scheduler state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package w_sched_pkg;

    localparam logic [1:0] LYR_G2 = 2'd0;
    localparam logic [1:0] LYR_G3 = 2'd1;
    localparam logic [1:0] LYR_D2 = 2'd2;
    localparam logic [1:0] LYR_D3 = 2'd3;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_N_INPUT = 2;
    localparam int DEF_N_G_L2  = 3;
    localparam int DEF_N_G_L3  = 9;
    localparam int DEF_N_D_L2  = 3;
    localparam int DEF_N_D_L3  = 1;
    localparam int DEF_MAX_FAN = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/w_row_sel.sv
// ============================================================================
// Module  : w_row_sel
// Purpose : Combinational row slicer: picks the layer bus, extracts one
//           neuron's weight row and zero-pads it to MAX_FAN words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module w_row_sel
    import w_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_INPUT = DEF_N_INPUT,
    parameter int N_G_L2  = DEF_N_G_L2,
    parameter int N_G_L3  = DEF_N_G_L3,
    parameter int N_D_L2  = DEF_N_D_L2,
    parameter int N_D_L3  = DEF_N_D_L3,
    parameter int MAX_FAN = DEF_MAX_FAN
) (
    input  logic [1:0]                        layer,
    input  logic [3:0]                        neuron_idx,
    input  logic [N_INPUT*N_G_L2*WIDTH-1:0]   wg2,
    input  logic [N_G_L2*N_G_L3*WIDTH-1:0]    wg3,
    input  logic [N_G_L3*N_D_L2*WIDTH-1:0]    wd2,
    input  logic [N_D_L2*N_D_L3*WIDTH-1:0]    wd3,
    output logic [MAX_FAN*WIDTH-1:0]          row_data,
    output logic [3:0]                        n_in,
    output logic                              row_last
);

    localparam int c_row_w = MAX_FAN * WIDTH;

    // Every neuron of every layer pre-padded to a full row; the mux below only selects.
    logic [N_G_L2*c_row_w-1:0] w_g2_rows;
    logic [N_G_L3*c_row_w-1:0] w_g3_rows;
    logic [N_D_L2*c_row_w-1:0] w_d2_rows;
    logic [N_D_L3*c_row_w-1:0] w_d3_rows;

    for (genvar j = 0; j < N_G_L2; j++) begin : g_g2_row
        for (genvar k = 0; k < MAX_FAN; k++) begin : g_word
            if (k < N_INPUT) begin : g_live
                assign w_g2_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = wg2[(j*N_INPUT+k)*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_g2_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = '0;
            end
        end
    end

    for (genvar j = 0; j < N_G_L3; j++) begin : g_g3_row
        for (genvar k = 0; k < MAX_FAN; k++) begin : g_word
            if (k < N_G_L2) begin : g_live
                assign w_g3_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = wg3[(j*N_G_L2+k)*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_g3_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = '0;
            end
        end
    end

    for (genvar j = 0; j < N_D_L2; j++) begin : g_d2_row
        for (genvar k = 0; k < MAX_FAN; k++) begin : g_word
            if (k < N_G_L3) begin : g_live
                assign w_d2_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = wd2[(j*N_G_L3+k)*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_d2_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = '0;
            end
        end
    end

    for (genvar j = 0; j < N_D_L3; j++) begin : g_d3_row
        for (genvar k = 0; k < MAX_FAN; k++) begin : g_word
            if (k < N_D_L2) begin : g_live
                assign w_d3_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = wd3[(j*N_D_L2+k)*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_d3_rows[(j*MAX_FAN+k)*WIDTH +: WIDTH] = '0;
            end
        end
    end

    always_comb begin
        row_data = '0;
        n_in     = '0;
        row_last = 1'b0;
        case (layer)
            LYR_G2: begin
                n_in     = 4'(N_INPUT);
                row_last = (neuron_idx == 4'(N_G_L2 - 1));
                for (int j = 0; j < N_G_L2; j++)
                    if (neuron_idx == 4'(j)) row_data = w_g2_rows[j*c_row_w +: c_row_w];
            end
            LYR_G3: begin
                n_in     = 4'(N_G_L2);
                row_last = (neuron_idx == 4'(N_G_L3 - 1));
                for (int j = 0; j < N_G_L3; j++)
                    if (neuron_idx == 4'(j)) row_data = w_g3_rows[j*c_row_w +: c_row_w];
            end
            LYR_D2: begin
                n_in     = 4'(N_G_L3);
                row_last = (neuron_idx == 4'(N_D_L2 - 1));
                for (int j = 0; j < N_D_L2; j++)
                    if (neuron_idx == 4'(j)) row_data = w_d2_rows[j*c_row_w +: c_row_w];
            end
            default: begin
                n_in     = 4'(N_D_L2);
                row_last = (neuron_idx == 4'(N_D_L3 - 1));
                for (int j = 0; j < N_D_L3; j++)
                    if (neuron_idx == 4'(j)) row_data = w_d3_rows[j*c_row_w +: c_row_w];
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/w_sched.sv
// ============================================================================
// Module  : w_sched
// Purpose : Layer/neuron scheduler for w_mem; walks G2->G3->D2->D3 presenting
//           one weight row per valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module w_sched
    import w_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_INPUT = DEF_N_INPUT,
    parameter int N_G_L2  = DEF_N_G_L2,
    parameter int N_G_L3  = DEF_N_G_L3,
    parameter int N_D_L2  = DEF_N_D_L2,
    parameter int N_D_L3  = DEF_N_D_L3,
    parameter int MAX_FAN = DEF_MAX_FAN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [3:0]                        choice_in,
    output logic [3:0]                        choice,
    input  logic [N_INPUT*N_G_L2*WIDTH-1:0]   wg2,
    input  logic [N_G_L2*N_G_L3*WIDTH-1:0]    wg3,
    input  logic [N_G_L3*N_D_L2*WIDTH-1:0]    wd2,
    input  logic [N_D_L2*N_D_L3*WIDTH-1:0]    wd3,
    output logic                              row_valid,
    input  logic                              row_ready,
    output logic [MAX_FAN*WIDTH-1:0]          row_data,
    output logic [1:0]                        layer,
    output logic [3:0]                        neuron_idx,
    output logic [3:0]                        n_in,
    output logic                              row_last,
    output logic                              busy,
    output logic                              done
);

    state_t r_state;
    logic   w_fire;

    assign w_fire = row_valid & row_ready;

    w_row_sel #(
        .WIDTH   (WIDTH),
        .N_INPUT (N_INPUT),
        .N_G_L2  (N_G_L2),
        .N_G_L3  (N_G_L3),
        .N_D_L2  (N_D_L2),
        .N_D_L3  (N_D_L3),
        .MAX_FAN (MAX_FAN)
    ) u_row_sel (
        .layer      (layer),
        .neuron_idx (neuron_idx),
        .wg2        (wg2),
        .wg3        (wg3),
        .wd2        (wd2),
        .wd3        (wd3),
        .row_data   (row_data),
        .n_in       (n_in),
        .row_last   (row_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            choice     <= '0;
            layer      <= LYR_G2;
            neuron_idx <= '0;
            row_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        choice     <= choice_in;
                        layer      <= LYR_G2;
                        neuron_idx <= '0;
                        busy       <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                // w_mem needs one cycle to reflect the freshly latched choice.
                ST_LOAD: begin
                    row_valid <= 1'b1;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_fire) begin
                        if (!row_last) begin
                            neuron_idx <= neuron_idx + 4'd1;
                        end else if (layer != LYR_D3) begin
                            layer      <= layer + 2'd1;
                            neuron_idx <= '0;
                        end else begin
                            row_valid <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    row_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
